// File: rtl/sata_defines_pkg.sv
// Shared SATA primitive constants and helpers for the transmit path.
// The LFSR step is the Galois form of x^16+x^15+x^13+x^4+1.
package sata_defines_pkg;

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_CONT  = 32'h9999AA7C;
  localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
  localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] PRIM_X_RDY = 32'h5757B57C;
  localparam logic [31:0] PRIM_R_RDY = 32'h4A4A957C;
  localparam logic [31:0] PRIM_R_IP  = 32'h5555B57C;
  localparam logic [31:0] PRIM_R_OK  = 32'h3535B57C;
  localparam logic [31:0] PRIM_R_ERR = 32'h5656B57C;
  localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] PRIM_HOLDA = 32'h9595AA7C;
  localparam logic [31:0] PRIM_WTRM  = 32'h5858B57C;

  localparam logic [3:0] K_PRIM = 4'b0001;
  localparam logic [3:0] K_DATA = 4'b0000;

  // Right-shift Galois mask: taps at exponents 16, 15, 13 and 4.
  localparam logic [15:0] JUNK_POLY_MASK = 16'hD008;

  typedef enum logic [1:0] {
    CONT_NONE,
    CONT_ONCE,
    CONT_TWICE,
    CONT_JUNK
  } cont_state_t;

  function automatic logic is_cont_candidate(input logic [31:0] dword, input logic is_k);
    return is_k && (dword != PRIM_ALIGN) && (dword != PRIM_CONT) &&
           (dword != PRIM_SOF) && (dword != PRIM_EOF);
  endfunction

  function automatic logic [15:0] junk_lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ JUNK_POLY_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/sata_cont_junk_lfsr.sv
// Scrambled junk source used after CONT: 16-bit Galois LFSR yielding two
// successive states per dword and advancing by two steps when enabled.
module sata_cont_junk_lfsr
  import sata_defines_pkg::*;
#(
  parameter logic [15:0] JUNK_SEED = 16'hFFFF
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  output logic [31:0] dout
);

  logic [15:0] state;
  logic [15:0] step1;
  logic [15:0] step2;

  always_comb begin
    step1 = junk_lfsr_step(state);
    step2 = junk_lfsr_step(step1);
    dout  = {state, step1};
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= JUNK_SEED;
    end else if (en) begin
      state <= step2;
    end
  end

endmodule

// File: rtl/sata_tx_prim_cont.sv
// Transmit stage feeding the PHY: periodic ALIGN insertion with link-layer
// back-pressure, plus primitive repeat suppression (prim, prim, CONT, junk).
module sata_tx_prim_cont
  import sata_defines_pkg::*;
#(
  parameter int          ALIGN_INTERVAL = 256,
  parameter int          ALIGN_COUNT    = 2,
  parameter logic [15:0] JUNK_SEED      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_ready_in,
  input  logic        cont_en,
  input  logic [31:0] in_dout,
  input  logic        in_is_k,
  output logic        in_ready,
  output logic [31:0] tx_dout,
  output logic [3:0]  tx_is_k,
  output logic        cont_active
);

  localparam int CW = $clog2(ALIGN_INTERVAL);
  localparam logic [CW-1:0] WIN_LAST   = CW'(ALIGN_INTERVAL - 1);
  localparam logic [CW-1:0] DATA_SLOTS = CW'(ALIGN_INTERVAL - ALIGN_COUNT);

  logic [CW-1:0] win_cnt;
  logic [CW-1:0] cnt_next;
  logic          link_up;
  cont_state_t   cont_state;
  logic [31:0]   last_prim;
  logic          same_prim;
  logic          data_slot;
  logic          lfsr_load;
  logic          lfsr_en;
  logic [31:0]   junk_dword;

  // in_ready is registered, so a data slot is exactly a cycle where it is high.
  always_comb begin
    same_prim = cont_en && in_is_k && (in_dout == last_prim) && (cont_state != CONT_NONE);
    data_slot = phy_ready_in && link_up && in_ready;
    lfsr_load = data_slot && same_prim && (cont_state == CONT_TWICE);
    lfsr_en   = data_slot && same_prim && (cont_state == CONT_JUNK);
    cnt_next  = (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
  end

  sata_cont_junk_lfsr #(
    .JUNK_SEED (JUNK_SEED)
  ) u_junk_lfsr (
    .rst  (rst),
    .clk  (clk),
    .load (lfsr_load),
    .en   (lfsr_en),
    .dout (junk_dword)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_dout     <= PRIM_ALIGN;
      tx_is_k     <= K_PRIM;
      in_ready    <= 1'b0;
      cont_active <= 1'b0;
      win_cnt     <= '0;
      link_up     <= 1'b0;
      cont_state  <= CONT_NONE;
      last_prim   <= '0;
    end else if (!phy_ready_in) begin
      tx_dout     <= PRIM_ALIGN;
      tx_is_k     <= K_PRIM;
      in_ready    <= 1'b0;
      cont_active <= 1'b0;
      win_cnt     <= '0;
      link_up     <= 1'b0;
      cont_state  <= CONT_NONE;
    end else if (!link_up) begin
      // First cycle after link-up has nothing consumed yet; open slot 0.
      tx_dout     <= PRIM_ALIGN;
      tx_is_k     <= K_PRIM;
      in_ready    <= 1'b1;
      cont_active <= 1'b0;
      link_up     <= 1'b1;
    end else if (in_ready) begin
      win_cnt  <= cnt_next;
      in_ready <= (cnt_next < DATA_SLOTS);
      if (same_prim) begin
        case (cont_state)
          CONT_ONCE: begin
            tx_dout     <= in_dout;
            tx_is_k     <= K_PRIM;
            cont_active <= 1'b0;
            cont_state  <= CONT_TWICE;
          end
          CONT_TWICE: begin
            tx_dout     <= PRIM_CONT;
            tx_is_k     <= K_PRIM;
            cont_active <= 1'b0;
            cont_state  <= CONT_JUNK;
          end
          CONT_JUNK: begin
            tx_dout     <= junk_dword;
            tx_is_k     <= K_DATA;
            cont_active <= 1'b1;
          end
          default: begin
            tx_dout     <= in_dout;
            tx_is_k     <= K_PRIM;
            cont_active <= 1'b0;
          end
        endcase
      end else begin
        tx_dout     <= in_dout;
        tx_is_k     <= in_is_k ? K_PRIM : K_DATA;
        cont_active <= 1'b0;
        if (cont_en && is_cont_candidate(in_dout, in_is_k)) begin
          last_prim  <= in_dout;
          cont_state <= CONT_ONCE;
        end else begin
          cont_state <= CONT_NONE;
        end
      end
    end else begin
      // ALIGN burst: cont state and LFSR are left untouched.
      tx_dout     <= PRIM_ALIGN;
      tx_is_k     <= K_PRIM;
      cont_active <= 1'b0;
      win_cnt     <= cnt_next;
      in_ready    <= (cnt_next < DATA_SLOTS);
    end
  end

endmodule

// File: tb/tb_sata_tx_prim_cont.sv
// Bench for sata_tx_prim_cont: directed scenarios plus randomized primitive
// streams, checked against a run-length reference model of the output stream.
module tb_sata_tx_prim_cont;

  localparam int INTERVAL = 256;
  localparam int NALIGN   = 2;
  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] CONT  = 32'h9999AA7C;
  localparam logic [31:0] SOF   = 32'h3737B57C;
  localparam logic [31:0] EOF   = 32'hD5D5B57C;
  localparam logic [31:0] SYNC  = 32'hB5B5957C;
  localparam logic [31:0] XRDY  = 32'h5757B57C;
  localparam logic [31:0] RRDY  = 32'h4A4A957C;
  localparam logic [31:0] HOLD  = 32'hD5D5AA7C;

  logic        clk = 1'b0;
  logic        rst;
  logic        phy_ready_in;
  logic        cont_en;
  logic [31:0] in_dout;
  logic        in_is_k;
  logic        in_ready;
  logic [31:0] tx_dout;
  logic [3:0]  tx_is_k;
  logic        cont_active;

  always #5 clk = ~clk;

  sata_tx_prim_cont #(
    .ALIGN_INTERVAL (INTERVAL),
    .ALIGN_COUNT    (NALIGN),
    .JUNK_SEED      (16'hFFFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .phy_ready_in (phy_ready_in),
    .cont_en      (cont_en),
    .in_dout      (in_dout),
    .in_is_k      (in_is_k),
    .in_ready     (in_ready),
    .tx_dout      (tx_dout),
    .tx_is_k      (tx_is_k),
    .cont_active  (cont_active)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] lfsr_seq [0:4095];

  // Reference model state: output position, run length of identical primitives.
  logic        m_up = 1'b0;
  int          m_pos = 0;
  int          m_run = 0;
  logic [31:0] m_last = '0;
  logic        m_consumed = 1'b0;
  logic [31:0] exp_dout = ALIGN;
  logic [3:0]  exp_k = 4'b0001;
  logic        exp_rdy = 1'b0;
  logic        exp_act = 1'b0;

  function automatic logic [15:0] galois(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hD008) : (s >> 1);
  endfunction

  function automatic logic [31:0] junk_word(input int k);
    int idx;
    idx = (k > 2046) ? 2046 : k;
    return {lfsr_seq[2*idx], lfsr_seq[2*idx+1]};
  endfunction

  // k-th output of a held primitive run: prim, prim, CONT, junk0, junk1, ...
  function automatic void run_expect(input logic [31:0] prim, input int k,
                                     output logic [31:0] d, output logic [3:0] kk,
                                     output logic a);
    if (k < 2) begin
      d = prim; kk = 4'b0001; a = 1'b0;
    end else if (k == 2) begin
      d = CONT; kk = 4'b0001; a = 1'b0;
    end else begin
      d = junk_word(k - 3); kk = 4'b0000; a = 1'b1;
    end
  endfunction

  task automatic model_edge(input logic phy, input logic en, input logic [31:0] d,
                            input logic k, input logic r);
    logic cand;
    m_consumed = 1'b0;
    if (r) begin
      m_up = 1'b0; m_pos = 0; m_run = 0;
      exp_dout = ALIGN; exp_k = 4'b0001; exp_rdy = 1'b0; exp_act = 1'b0;
    end else if (!phy) begin
      m_up = 1'b0; m_pos = 0; m_run = 0;
      exp_dout = ALIGN; exp_k = 4'b0001; exp_rdy = 1'b0; exp_act = 1'b0;
    end else if (!m_up) begin
      m_up = 1'b1;
      exp_dout = ALIGN; exp_k = 4'b0001; exp_rdy = 1'b1; exp_act = 1'b0;
    end else if (m_pos >= INTERVAL - NALIGN) begin
      exp_dout = ALIGN; exp_k = 4'b0001; exp_act = 1'b0;
      m_pos = (m_pos + 1) % INTERVAL;
      exp_rdy = (m_pos < INTERVAL - NALIGN);
    end else begin
      m_consumed = 1'b1;
      cand = k && d != ALIGN && d != CONT && d != SOF && d != EOF;
      if (en && cand) begin
        m_run = (m_run > 0 && d == m_last) ? m_run + 1 : 1;
        m_last = d;
      end else begin
        m_run = 0;
      end
      if (m_run >= 4) begin
        exp_dout = junk_word(m_run - 4); exp_k = 4'b0000; exp_act = 1'b1;
      end else if (m_run == 3) begin
        exp_dout = CONT; exp_k = 4'b0001; exp_act = 1'b0;
      end else begin
        exp_dout = d; exp_k = k ? 4'b0001 : 4'b0000; exp_act = 1'b0;
      end
      m_pos = (m_pos + 1) % INTERVAL;
      exp_rdy = (m_pos < INTERVAL - NALIGN);
    end
  endtask

  task automatic step(input logic phy, input logic en, input logic [31:0] d, input logic k);
    phy_ready_in = phy;
    cont_en      = en;
    in_dout      = d;
    in_is_k      = k;
    @(posedge clk);
    model_edge(phy, en, d, k, rst);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({tx_dout, tx_is_k, in_ready, cont_active} !== {ALIGN, 4'b0001, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset got dout=%h k=%b rdy=%b act=%b exp dout=%h k=0001 rdy=0 act=0",
               tx_dout, tx_is_k, in_ready, cont_active, ALIGN);
    end
    rst = 1'b0;
  endtask

  task automatic test_windows();
    int seq;
    int out_seq;
    int p;
    logic exp_r;
    logic [31:0] exp_d;
    seq = 0;
    out_seq = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (tx_dout !== ALIGN || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL link_down got dout=%h rdy=%b exp dout=%h rdy=0", tx_dout, in_ready, ALIGN);
      end
    end
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 1'b0, 32'(seq), 1'b0);
      if (m_consumed) seq++;
      checks++;
      if ({tx_dout, tx_is_k, in_ready, cont_active} !== {exp_dout, exp_k, exp_rdy, exp_act}) begin
        errors++;
        $display("[TB] FAIL windows_model cyc=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", i,
                 tx_dout, tx_is_k, in_ready, cont_active, exp_dout, exp_k, exp_rdy, exp_act);
      end
      p = i - 1;
      exp_r = (((p + 1) % INTERVAL) < INTERVAL - NALIGN);
      if (i == 0) begin
        exp_d = ALIGN;
      end else if ((p % INTERVAL) >= INTERVAL - NALIGN) begin
        exp_d = ALIGN;
      end else begin
        exp_d = 32'(out_seq);
        out_seq++;
      end
      checks++;
      if (tx_dout !== exp_d || in_ready !== exp_r) begin
        errors++;
        $display("[TB] FAIL windows_pos pos=%0d got dout=%h rdy=%b exp dout=%h rdy=%b",
                 p, tx_dout, in_ready, exp_d, exp_r);
      end
    end
  endtask

  task automatic test_cont_sync();
    logic [31:0] d;
    logic [3:0] kk;
    logic a;
    step(1'b0, 1'b1, SYNC, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      step(1'b1, 1'b1, SYNC, 1'b1);
      if (i == 0) begin
        d = ALIGN; kk = 4'b0001; a = 1'b0;
      end else begin
        run_expect(SYNC, i - 1, d, kk, a);
      end
      checks++;
      if ({tx_dout, tx_is_k, cont_active} !== {d, kk, a} ||
          {tx_dout, tx_is_k, in_ready, cont_active} !== {exp_dout, exp_k, exp_rdy, exp_act}) begin
        errors++;
        $display("[TB] FAIL cont_sync k=%0d got %h/%b/act=%b exp %h/%b/act=%b",
                 i - 1, tx_dout, tx_is_k, cont_active, d, kk, a);
      end
    end
  endtask

  task automatic test_switch();
    logic [31:0] d;
    logic [3:0] kk;
    logic a;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, XRDY, 1'b1);
      run_expect(XRDY, k, d, kk, a);
      checks++;
      if ({tx_dout, tx_is_k, cont_active} !== {d, kk, a} ||
          {tx_dout, tx_is_k, in_ready, cont_active} !== {exp_dout, exp_k, exp_rdy, exp_act}) begin
        errors++;
        $display("[TB] FAIL switch k=%0d got %h/%b/act=%b exp %h/%b/act=%b",
                 k, tx_dout, tx_is_k, cont_active, d, kk, a);
      end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] d;
    logic [3:0] kk;
    logic a;
    int k;
    int p;
    k = 5;
    for (int i = 0; i < 250; i++) begin
      p = 15 + i;
      step(1'b1, 1'b1, XRDY, 1'b1);
      if ((p % INTERVAL) >= INTERVAL - NALIGN) begin
        d = ALIGN; kk = 4'b0001; a = 1'b0;
      end else begin
        run_expect(XRDY, k, d, kk, a);
        k++;
      end
      checks++;
      if ({tx_dout, tx_is_k, cont_active} !== {d, kk, a} ||
          {tx_dout, tx_is_k, in_ready, cont_active} !== {exp_dout, exp_k, exp_rdy, exp_act}) begin
        errors++;
        $display("[TB] FAIL boundary pos=%0d got %h/%b/act=%b exp %h/%b/act=%b",
                 p, tx_dout, tx_is_k, cont_active, d, kk, a);
      end
    end
  endtask

  task automatic test_link_drop();
    logic [31:0] d;
    logic [3:0] kk;
    logic a;
    int k;
    for (int i = 0; i < 4; i++) begin
      step(i < 3 ? 1'b0 : 1'b1, 1'b1, XRDY, 1'b1);
      checks++;
      if ({tx_dout, tx_is_k, in_ready, cont_active} !== {ALIGN, 4'b0001, (i == 3), 1'b0}) begin
        errors++;
        $display("[TB] FAIL link_drop cyc=%0d got %h/%b/rdy=%b/act=%b exp %h/0001/rdy=%b/act=0",
                 i, tx_dout, tx_is_k, in_ready, cont_active, ALIGN, (i == 3));
      end
    end
    k = 0;
    for (int p = 0; p < 258; p++) begin
      step(1'b1, 1'b1, XRDY, 1'b1);
      if (p >= INTERVAL - NALIGN && p < INTERVAL) begin
        d = ALIGN; kk = 4'b0001; a = 1'b0;
      end else begin
        run_expect(XRDY, k, d, kk, a);
        k++;
      end
      checks++;
      if ({tx_dout, tx_is_k, cont_active} !== {d, kk, a} ||
          {tx_dout, tx_is_k, in_ready, cont_active} !== {exp_dout, exp_k, exp_rdy, exp_act}) begin
        errors++;
        $display("[TB] FAIL link_return pos=%0d got %h/%b/act=%b exp %h/%b/act=%b",
                 p, tx_dout, tx_is_k, cont_active, d, kk, a);
      end
    end
  endtask

  task automatic test_cont_off();
    int holds;
    holds = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, HOLD, 1'b1);
      if (tx_dout === HOLD) holds++;
      checks++;
      if ({tx_dout, tx_is_k, cont_active} !== {HOLD, 4'b0001, 1'b0} ||
          {tx_dout, tx_is_k, in_ready, cont_active} !== {exp_dout, exp_k, exp_rdy, exp_act}) begin
        errors++;
        $display("[TB] FAIL cont_off cyc=%0d got %h/%b/act=%b exp %h/0001/act=0",
                 i, tx_dout, tx_is_k, cont_active, HOLD);
      end
    end
    checks++;
    if (holds !== 20) begin
      errors++;
      $display("[TB] FAIL cont_off_count got %0d exp 20", holds);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic k;
    logic en;
    logic phy;
    int len;
    int drop;
    drop = 0;
    for (int seg = 0; seg < 150; seg++) begin
      k = 1'b1;
      case ($urandom_range(0, 9))
        0: d = SYNC;
        1: d = HOLD;
        2: d = XRDY;
        3: d = RRDY;
        4: d = ALIGN;
        5: d = CONT;
        6: d = SOF;
        7: d = EOF;
        8: d = $urandom();
        default: begin d = $urandom(); k = 1'b0; end
      endcase
      if ($urandom_range(0, 2) == 0) d = SYNC;
      len = $urandom_range(1, 12);
      en = ($urandom_range(0, 9) != 0);
      for (int j = 0; j < len; j++) begin
        phy = 1'b1;
        if (drop == 0 && $urandom_range(0, 49) == 0) drop = $urandom_range(1, 3);
        if (drop > 0) begin
          phy = 1'b0;
          drop--;
        end
        step(phy, en, d, k);
        checks++;
        if ({tx_dout, tx_is_k, in_ready, cont_active} !== {exp_dout, exp_k, exp_rdy, exp_act}) begin
          errors++;
          $display("[TB] FAIL random seg=%0d j=%0d got %h/%b/%b/%b exp %h/%b/%b/%b", seg, j,
                   tx_dout, tx_is_k, in_ready, cont_active, exp_dout, exp_k, exp_rdy, exp_act);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    phy_ready_in = 1'b0;
    cont_en = 1'b0;
    in_dout = '0;
    in_is_k = 1'b0;
    lfsr_seq[0] = 16'hFFFF;
    for (int i = 1; i < 4096; i++) lfsr_seq[i] = galois(lfsr_seq[i-1]);
    test_reset();
    test_windows();
    test_cont_sync();
    test_switch();
    test_boundary();
    test_link_drop();
    test_cont_off();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
